// File: rtl/unidade_controle_if.sv
// Bus between an instruction source and the control unit: handshake in,
// register-bank / ALU control and status out.
interface unidade_controle_if #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 3
);
  logic                     instr_valid;
  logic [bits_palavra-1:0]  instr;
  logic                     instr_ready;
  logic                     hab_escrita;
  logic [end_registros-1:0] sel_e_sa;
  logic [end_registros-1:0] sel_sb;
  logic [3:0]               alu_op;
  logic                     sel_mux_e;
  logic [bits_palavra-1:0]  imm_ext;
  logic                     done;
  logic                     illegal;
  logic [15:0]              retired;

  // Instruction source side
  modport master (
    output instr_valid, instr,
    input  instr_ready, hab_escrita, sel_e_sa, sel_sb, alu_op,
           sel_mux_e, imm_ext, done, illegal, retired
  );

  // Control unit side
  modport slave (
    input  instr_valid, instr,
    output instr_ready, hab_escrita, sel_e_sa, sel_sb, alu_op,
           sel_mux_e, imm_ext, done, illegal, retired
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: accepts one instruction at a time, sequences
// DECODE/READ/EXEC/WRITE and drives register-bank and ALU controls.
// Word layout: opcode [15:12], rd [11:9], rb [8:6], imm [8:0].
module unidade_controle #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 3
) (
  input logic               clock,
  input logic               reset,
  unidade_controle_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    EXEC,
    WRITE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [bits_palavra-1:0] instr_q;
  logic                    illegal_q;
  logic [15:0]             retired_q;
  logic                    done_c;

  logic [3:0]               opcode;
  logic [end_registros-1:0] rd;
  logic [end_registros-1:0] rb;
  logic                     op_nop;
  logic                     op_li;
  logic                     op_ill;

  assign opcode = instr_q[15:12];
  assign rd     = end_registros'(instr_q[11:9]);
  assign rb     = end_registros'(instr_q[8:6]);
  assign op_nop = (opcode == 4'b0000);
  assign op_li  = (opcode == 4'b1001);
  assign op_ill = (opcode >= 4'b1011);

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: IDLE waits for the handshake, DECODE picks the path by opcode class
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.instr_valid) state_next = DECODE;
      DECODE: begin
        if (op_nop || op_ill) state_next = IDLE;
        else if (op_li)       state_next = WRITE;
        else                  state_next = READ;
      end
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: all controls are a function of the state and latched word only
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.hab_escrita = 1'b0;
    bus.sel_e_sa    = '0;
    bus.sel_sb      = '0;
    bus.alu_op      = 4'b0000;
    bus.sel_mux_e   = 1'b0;
    done_c          = 1'b0;
    case (state)
      IDLE:   bus.instr_ready = 1'b1;
      DECODE: done_c = op_nop;
      READ: begin
        bus.sel_e_sa = rd;
        bus.sel_sb   = rb;
      end
      EXEC: begin
        bus.sel_e_sa = rd;
        bus.sel_sb   = rb;
        bus.alu_op   = opcode;
      end
      WRITE: begin
        bus.sel_e_sa    = rd;
        bus.sel_sb      = rb;
        bus.alu_op      = opcode;
        bus.hab_escrita = 1'b1;
        bus.sel_mux_e   = op_li;
        done_c          = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.done    = done_c;
  assign bus.imm_ext = {{(bits_palavra-9){1'b0}}, instr_q[8:0]};
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

  // Capture the instruction word on the handshake; later offers are ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                instr_q <= '0;
    else if (state == IDLE && bus.instr_valid) instr_q <= bus.instr;
  end

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          illegal_q <= 1'b0;
    else if (state == DECODE && op_ill) illegal_q <= 1'b1;
  end

  // Retired counter bumps as the unit leaves a done state; wraps naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       retired_q <= 16'h0000;
    else if (done_c) retired_q <= retired_q + 16'h0001;
  end

endmodule
